// File: rtl/stream_decipher.sv
// stream_decipher: byte-stream XOR decipher driven by an 8-bit LFSR keystream.
// One-deep output register with valid/ready handshake; keystream only
// advances when a ciphertext byte is actually accepted.
module stream_decipher (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_seed,
    input  logic [7:0]  seed_in,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        seeded,
    output logic [15:0] byte_count
);

    typedef enum logic {
        UNSEEDED = 1'b0,
        RUN      = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_lfsr;
    logic [7:0]  r_out_data;
    logic        r_out_valid;
    logic [15:0] r_byte_count;
    logic        w_in_ready;
    logic        w_accept;

    // Next keystream byte: shift left, feedback from taps 7,5,4,3.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    // A zero seed would lock the LFSR, so it is replaced by 0x01.
    function automatic logic [7:0] seed_fix(input logic [7:0] sd);
        return (sd == 8'h00) ? 8'h01 : sd;
    endfunction

    // Accept only when running, not re-seeding, and the output slot is free
    // or being drained this cycle.
    assign w_in_ready = (r_state == RUN) && !load_seed && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= UNSEEDED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: any seed load moves to (or stays in) RUN.
    always_comb begin
        w_state_nxt = r_state;
        if (load_seed) begin
            w_state_nxt = RUN;
        end
    end

    // Datapath: seed load has priority, then input accept, then output drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr       <= 8'h01;
            r_out_data   <= 8'h00;
            r_out_valid  <= 1'b0;
            r_byte_count <= 16'h0000;
        end else if (load_seed) begin
            r_lfsr       <= seed_fix(seed_in);
            r_out_valid  <= 1'b0;
            r_byte_count <= 16'h0000;
        end else if (w_accept) begin
            r_out_data   <= in_data ^ r_lfsr;
            r_out_valid  <= 1'b1;
            r_lfsr       <= lfsr_step(r_lfsr);
            r_byte_count <= r_byte_count + 16'd1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign seeded     = (r_state == RUN);
    assign byte_count = r_byte_count;

endmodule

// File: tb/tb_stream_decipher.sv
// Testbench for stream_decipher: directed vector table, hand-written
// reset/unseeded sequences, randomized traffic against a keystream-table
// model, and a full 16-bit byte counter wrap.
module tb_stream_decipher;

    logic        clk;
    logic        rst_n;
    logic        load_seed;
    logic [7:0]  seed_in;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        seeded;
    logic [15:0] byte_count;

    stream_decipher dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_seed  (load_seed),
        .seed_in    (seed_in),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .seeded     (seeded),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Keystream is precomputed as a table indexed by the number of bytes
    // accepted since the last seed.
    logic [7:0] ks_tab [0:69999];
    bit         m_seeded;
    bit         m_ov;
    logic [7:0] m_od;
    int         m_pos;

    task automatic gen_ks(input logic [7:0] sd, input int len);
        logic [7:0] k;
        k = (sd == 8'h00) ? 8'h01 : sd;
        for (int i = 0; i < len; i++) begin
            ks_tab[i] = k;
            k = {k[6:0], k[7] ^ k[5] ^ k[4] ^ k[3]};
        end
    endtask

    task automatic model_reset();
        m_seeded = 0;
        m_ov     = 0;
        m_od     = 8'h00;
        m_pos    = 0;
    endtask

    // Apply the currently driven inputs for one clock and check against the model.
    task automatic model_cycle(input int ks_len);
        bit exp_ir;
        exp_ir = m_seeded && !load_seed && (!m_ov || out_ready);
        #1;
        chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
        @(posedge clk);
        #1;
        if (load_seed) begin
            m_seeded = 1;
            gen_ks(seed_in, ks_len);
            m_pos = 0;
            m_ov  = 0;
        end else if (exp_ir && in_valid) begin
            m_od  = in_data ^ ks_tab[m_pos];
            m_pos = m_pos + 1;
            m_ov  = 1;
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
        chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        if (m_ov) chk("rnd_out_data", {24'd0, out_data}, {24'd0, m_od});
        chk("rnd_byte_count", {16'd0, byte_count}, {16'd0, m_pos[15:0]});
        chk("rnd_seeded", {31'd0, seeded}, {31'd0, m_seeded});
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ld;
        logic [7:0]  seed;
        logic        iv;
        logic [7:0]  id;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [7:0]  e_od;
        logic        c_od;
        logic [15:0] e_cnt;
        logic        e_sd;
    } vec_t;

    vec_t vec [0:20];

    function automatic vec_t mk(input logic ld, input logic [7:0] seed, input logic iv,
                                input logic [7:0] id, input logic ordy, input logic e_ir,
                                input logic e_ov, input logic [7:0] e_od, input logic c_od,
                                input logic [15:0] e_cnt, input logic e_sd);
        vec_t v;
        v.ld = ld; v.seed = seed; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.c_od = c_od;
        v.e_cnt = e_cnt; v.e_sd = e_sd;
        return v;
    endfunction

    task automatic drive_idle();
        load_seed = 1'b0;
        seed_in   = 8'h00;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic decrypt, seed 0x01: keystream 01,02,04,08,11
        vec[0]  = mk(1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1);
        vec[1]  = mk(1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 16'd1, 1'b1);
        vec[2]  = mk(1'b0, 8'h00, 1'b1, 8'h42, 1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 16'd2, 1'b1);
        vec[3]  = mk(1'b0, 8'h00, 1'b1, 8'h43, 1'b1, 1'b1, 1'b1, 8'h47, 1'b1, 16'd3, 1'b1);
        vec[4]  = mk(1'b0, 8'h00, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h4C, 1'b1, 16'd4, 1'b1);
        vec[5]  = mk(1'b0, 8'h00, 1'b1, 8'h45, 1'b1, 1'b1, 1'b1, 8'h54, 1'b1, 16'd5, 1'b1);
        vec[6]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd5, 1'b1);
        // Zero seed behaves as seed 0x01
        vec[7]  = mk(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1);
        vec[8]  = mk(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 16'd1, 1'b1);
        vec[9]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd1, 1'b1);
        // Backpressure: held byte, no keystream consumed while stalled
        vec[10] = mk(1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1);
        vec[11] = mk(1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 1'b1, 1'b1, 8'h40, 1'b1, 16'd1, 1'b1);
        vec[12] = mk(1'b0, 8'h00, 1'b1, 8'h50, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1, 16'd1, 1'b1);
        vec[13] = mk(1'b0, 8'h00, 1'b1, 8'h50, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1, 16'd1, 1'b1);
        vec[14] = mk(1'b0, 8'h00, 1'b1, 8'h50, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1, 16'd1, 1'b1);
        vec[15] = mk(1'b0, 8'h00, 1'b1, 8'h50, 1'b1, 1'b1, 1'b1, 8'h52, 1'b1, 16'd2, 1'b1);
        vec[16] = mk(1'b0, 8'h00, 1'b1, 8'h43, 1'b1, 1'b1, 1'b1, 8'h47, 1'b1, 16'd3, 1'b1);
        // Re-seed while a byte is held
        vec[17] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h47, 1'b1, 16'd3, 1'b1);
        vec[18] = mk(1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1);
        vec[19] = mk(1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 16'd1, 1'b1);
        vec[20] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd1, 1'b1);

        drive_idle();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state, with a byte already offered
        in_valid = 1'b1;
        in_data  = 8'h5A;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'h00);
        chk("rst_byte_count", {16'd0, byte_count}, 32'd0);
        chk("rst_seeded", {31'd0, seeded}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);

        // Unseeded: offered bytes are never accepted
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("unseeded_in_ready", {31'd0, in_ready}, 32'd0);
            chk("unseeded_out_valid", {31'd0, out_valid}, 32'd0);
            chk("unseeded_byte_count", {16'd0, byte_count}, 32'd0);
        end

        // Vector table
        for (int i = 0; i < 21; i++) begin
            load_seed = vec[i].ld;
            seed_in   = vec[i].seed;
            in_valid  = vec[i].iv;
            in_data   = vec[i].id;
            out_ready = vec[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vec[i].e_ir});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vec[i].e_ov});
            if (vec[i].c_od)
                chk($sformatf("vec%0d_out_data", i), {24'd0, out_data}, {24'd0, vec[i].e_od});
            chk($sformatf("vec%0d_byte_count", i), {16'd0, byte_count}, {16'd0, vec[i].e_cnt});
            chk($sformatf("vec%0d_seeded", i), {31'd0, seeded}, {31'd0, vec[i].e_sd});
        end

        // Asynchronous reset mid-stream with a held byte
        drive_idle();
        in_valid  = 1'b1;
        in_data   = 8'h33;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_byte_count", {16'd0, byte_count}, 32'd0);
        chk("async_rst_seeded", {31'd0, seeded}, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_byte_count", {16'd0, byte_count}, 32'd0);

        // Randomized traffic against the model
        drive_idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2000; i++) begin
            load_seed = ($urandom_range(0, 49) == 0) || (i == 5);
            seed_in   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            model_cycle(4096);
        end

        // Counter wrap: 65536 accepts after a seed, then keep decrypting
        drive_idle();
        load_seed = 1'b1;
        seed_in   = 8'($urandom);
        model_cycle(70000);
        load_seed = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            in_data = 8'($urandom);
            model_cycle(70000);
        end
        chk("wrap_byte_count_zero", {16'd0, byte_count}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom);
            model_cycle(70000);
        end
        chk("wrap_byte_count_after", {16'd0, byte_count}, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
